// File: rtl/int_priority_arbiter.sv
// Fixed-priority interrupt arbiter with INTACK handshake, flag clear and
// a quiet gap before re-arbitration. NMI is edge-captured and always wins.
//
// Ports:
//   MCLK        system clock (rising edge)
//   RSTn        asynchronous active-low reset
//   GIE         global enable, gates maskable sources only
//   IE, IFG     per-source enable and level flag (NREQ bits)
//   NMI         synchronous non-maskable request, rising-edge sensitive
//   INTACKin    one-cycle CPU acknowledge of the presented request
//   INT         interrupt request to the CPU
//   IntAddrout  IVT index of the presented request, 0 when INT=0
//   IFGclr      one-cycle one-hot clear to the acknowledged source
//   busy        high whenever the sequencer is not idle
module int_priority_arbiter #(
    parameter int NREQ     = 8,
    parameter int IDX_BASE = 54,
    parameter int IDX_NMI  = 62,
    parameter int GAP      = 2
) (
    input  logic            MCLK,
    input  logic            RSTn,
    input  logic            GIE,
    input  logic [NREQ-1:0] IE,
    input  logic [NREQ-1:0] IFG,
    input  logic            NMI,
    input  logic            INTACKin,
    output logic            INT,
    output logic [5:0]      IntAddrout,
    output logic [NREQ-1:0] IFGclr,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic            nmi_q;
    logic            nmi_pend;
    logic            nmi_pend_n;
    logic            nmi_edge;
    logic            nmi_clr;
    logic            win_nmi;
    logic            win_nmi_n;
    logic [3:0]      win_idx;
    logic [3:0]      win_idx_n;
    logic [3:0]      gap_cnt;
    logic [3:0]      gap_cnt_n;
    logic [NREQ-1:0] elig;
    logic            elig_any;
    logic [3:0]      top_idx;
    logic            win_elig;

    assign elig     = IFG & IE & {NREQ{GIE}};
    assign elig_any = |elig;

    // Ascending scan: the last set bit seen is the highest-priority one.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (elig[i]) top_idx = 4'(i);
        end
    end

    // Is the latched maskable winner still eligible?
    always_comb begin
        win_elig = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 4'(i)) win_elig = elig[i];
        end
    end

    // A fresh edge in the clearing cycle wins over the clear.
    assign nmi_edge   = NMI & ~nmi_q;
    assign nmi_clr    = (state == S_ACK) & win_nmi;
    assign nmi_pend_n = nmi_edge | (nmi_pend & ~nmi_clr);

    always_comb begin
        state_n   = state;
        win_nmi_n = win_nmi;
        win_idx_n = win_idx;
        gap_cnt_n = gap_cnt;
        unique case (state)
            S_IDLE: begin
                if (nmi_pend) begin
                    win_nmi_n = 1'b1;
                    win_idx_n = '0;
                    state_n   = S_PEND;
                end else if (elig_any) begin
                    win_nmi_n = 1'b0;
                    win_idx_n = top_idx;
                    state_n   = S_PEND;
                end
            end
            S_PEND: begin
                // Acknowledge beats withdrawal in the same cycle.
                if (INTACKin) begin
                    state_n = S_ACK;
                end else if (!win_nmi && !win_elig) begin
                    state_n = S_IDLE;
                end
            end
            S_ACK: begin
                gap_cnt_n = 4'(GAP);
                state_n   = S_HOLD;
            end
            S_HOLD: begin
                gap_cnt_n = gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= S_IDLE;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
            win_nmi  <= 1'b0;
            win_idx  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            nmi_q    <= NMI;
            nmi_pend <= nmi_pend_n;
            win_nmi  <= win_nmi_n;
            win_idx  <= win_idx_n;
            gap_cnt  <= gap_cnt_n;
        end
    end

    // Outputs decode straight from the state so reset clears them at once.
    assign INT  = (state == S_PEND);
    assign busy = (state != S_IDLE);

    always_comb begin
        IntAddrout = '0;
        if (INT) begin
            if (win_nmi) IntAddrout = 6'(IDX_NMI);
            else         IntAddrout = 6'(IDX_BASE) + {2'b00, win_idx};
        end
    end

    always_comb begin
        IFGclr = '0;
        for (int i = 0; i < NREQ; i++) begin
            IFGclr[i] = (state == S_ACK) && !win_nmi && (win_idx == 4'(i));
        end
    end

endmodule

// File: doc/int_priority_arbiter.md
Name: int_priority_arbiter

Overview:
- Fixed-priority interrupt arbiter and handshake sequencer between the maskable/NMI peripheral interrupt sources and the CPU interrupt-accept logic.
- Selects one pending source and presents its IVT index to the CPU, holding it stable until the CPU's INTACK pulse.
- On INTACK it issues a one-cycle flag-clear to the winning source, then enforces a quiet gap before re-arbitrating.
- Reset vectoring sits upstream in the daisy chain and is outside this block's scope.

Parameters:
NREQ, 8, number of maskable sources (1..16); index NREQ-1 has the highest priority.
IDX_BASE, 54, IVT index of source 0; source i maps to IDX_BASE+i; IDX_BASE+NREQ-1 must be <= 62.
IDX_NMI, 62, IVT index presented for NMI.
GAP, 2, quiet cycles after a clear before re-arbitration (1..15).

Ports:
MCLK  in  1  system clock; all state changes on the rising edge.
RSTn  in  1  asynchronous, active-low reset.
GIE  in  1  CPU global interrupt enable; gates maskable sources only.
IE  in  NREQ  per-source interrupt enable.
IFG  in  NREQ  per-source interrupt flag (level, held by the source until cleared).
NMI  in  1  non-maskable request, already synchronous to MCLK; rising-edge sensitive.
INTACKin  in  1  one-cycle CPU acknowledge of the presented request.
INT  out  1  interrupt request to the CPU.
IntAddrout  out  6  IVT index of the presented request; 0 when INT=0.
IFGclr  out  NREQ  one-cycle one-hot clear to the acknowledged source.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE, INT=0, IntAddrout=0, IFGclr=0, busy=0, nmi_pend=0, NMI edge register=0, gap counter=0, latched index=0.
- NMI capture:
  - nmi_pend sets on the cycle after a 0->1 transition of NMI.
  - nmi_pend clears only in ACK when the latched winner is the NMI.
  - An edge arriving in the same cycle as that clear leaves nmi_pend set, so no NMI is lost.
- Eligible maskable set: E = IFG & IE & {NREQ{GIE}}.
- State IDLE:
  - If nmi_pend=1: latch the NMI as winner; go to PEND.
  - Otherwise, if E is nonzero: latch the highest set bit of E; go to PEND.
  - Otherwise stay in IDLE.
  - Arbitration is registered: INT rises one cycle after a request becomes eligible.
- State PEND:
  - INT=1; IntAddrout = IDX_NMI or IDX_BASE+winner.
  - Index is frozen; a later higher-priority request does not preempt it.
  - If INTACKin=1: go to ACK. This check has priority over withdrawal in the same cycle.
  - Else, if the winner is maskable and its E bit is 0 (IFG dropped, IE cleared, or GIE cleared): withdraw to IDLE with INT=0 next cycle.
  - An NMI winner never withdraws.
- State ACK (exactly one cycle):
  - INT=0, IntAddrout=0.
  - IFGclr[winner]=1 for a maskable winner; IFGclr=0 and nmi_pend cleared for an NMI winner.
  - Load gap counter with GAP; go to HOLD.
- State HOLD:
  - INT=0.
  - Decrement the counter each cycle; go to IDLE when it reaches 1.
  - This allows the source to drop IFG before re-arbitration.
- INTACKin outside PEND is ignored: no state change, no clear.
- Minimum request-to-request spacing for back-to-back sources: PEND, then ACK, then GAP cycles of HOLD, then IDLE, then PEND.
- busy=1 in PEND, ACK and HOLD.
- An asynchronous reset in any state immediately forces the reset values; no IFGclr pulse is emitted.

Test Plan:
- Single source: after reset, IE=0x08, IFG=0x08, GIE=1 → INT=1 with IntAddrout=57 one cycle later. Pulse INTACKin → next cycle IFGclr=0x08 for one cycle and INT=0. busy returns to 0 after GAP=2 HOLD cycles.
- Priority and no preemption:
  - IFG=IE=0x05 → index 56 presented.
  - Raising IFG bit 7 while in PEND keeps 56.
  - After the ack and gap, 61 is presented; then 54.
- Masking and withdrawal: in PEND on source 3, drop GIE → INT=0 next cycle, no IFGclr. Restore GIE → 57 re-presented after one IDLE cycle.
- NMI:
  - With GIE=0 and an NMI rising edge → INT=1 with IDX_NMI=62. NMI wins over simultaneous IFG=0xFF.
  - Ack → IFGclr=0 and nmi_pend cleared.
  - A second NMI edge in the ACK cycle → 62 re-presented after the gap.
- Boundary:
  - INTACKin in the same cycle the winner's IFG drops → ACK still occurs with IFGclr pulse.
  - INTACKin during IDLE or HOLD → no effect.
  - RSTn asserted mid-PEND → INT=0 and IntAddrout=0 immediately.
